// File: rtl/gate_test_sequencer.sv
// Stimulus/check sequencer for a 3-input gate under test: steps vectors onto a,b,c,
// waits a settle time, samples w_in against a truth table and reports the results.
module gate_test_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [7:0]  EXPECT_MASK   = 8'h7F
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       single,
   input  logic [2:0] vec_in,
   input  logic       w_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [7:0] fail_mask
);

   localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam int unsigned CNT_W      = $clog2(SETTLE_EFF + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t           state;
   logic [2:0]       vec;
   logic             single_q;
   logic [CNT_W-1:0] settle_cnt;

   logic       exp_bit_c;
   logic       mismatch_c;
   logic [3:0] err_next_c;

   // An X or Z on w_in never equals the expected bit, so it scores as a mismatch.
   assign exp_bit_c  = EXPECT_MASK[vec];
   assign mismatch_c = (w_in !== exp_bit_c);
   assign err_next_c = err_count + 4'(mismatch_c);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         vec        <= 3'd0;
         single_q   <= 1'b0;
         settle_cnt <= '0;
         a          <= 1'b0;
         b          <= 1'b0;
         c          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 4'd0;
         fail_mask  <= 8'h00;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  single_q  <= single;
                  vec       <= single ? vec_in : 3'd0;
                  err_count <= 4'd0;
                  fail_mask <= 8'h00;
                  busy      <= 1'b1;
                  state     <= S_APPLY;
               end
            end
            S_APPLY: begin
               {a, b, c}  <= vec;
               settle_cnt <= CNT_W'(SETTLE_EFF);
               state      <= S_SETTLE;
            end
            S_SETTLE: begin
               settle_cnt <= settle_cnt - CNT_W'(1);
               if (settle_cnt <= CNT_W'(1)) begin
                  state <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               if (mismatch_c) begin
                  fail_mask[vec] <= 1'b1;
                  err_count      <= err_next_c;
               end
               // pass is resolved here so it already reflects the final sample during done.
               if (single_q || (vec == 3'd7)) begin
                  done  <= 1'b1;
                  pass  <= (err_next_c == 4'd0);
                  state <= S_DONE;
               end else begin
                  vec   <= vec + 3'd1;
                  state <= S_APPLY;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
